// File: rtl/credit_counter_nch.sv
// rtl/credit_counter_nch.sv - multi-channel credit counter with level flags and sticky error flags
module credit_counter_nch #(
    parameter int CNT_BITWIDTH       = 8,
    parameter int CH_NUM             = 4,
    parameter int MAX_VALUE          = 2**CNT_BITWIDTH - 1,
    parameter int RESET_VALUE        = 0,
    parameter int ALMOST_EMPTY_LEVEL = 10,
    parameter int ALMOST_FULL_LEVEL  = 250,
    parameter int WRAP_MODE          = 0
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [CH_NUM-1:0]                inc_i,
    input  logic [CH_NUM-1:0]                dec_i,
    input  logic [CH_NUM-1:0]                load_i,
    input  logic [CH_NUM*CNT_BITWIDTH-1:0]   load_val_i,
    input  logic                             err_clr_i,
    output logic [CH_NUM*CNT_BITWIDTH-1:0]   counter_o,
    output logic [CH_NUM-1:0]                full_o,
    output logic [CH_NUM-1:0]                empty_o,
    output logic [CH_NUM-1:0]                almost_full_o,
    output logic [CH_NUM-1:0]                almost_empty_o,
    output logic [CH_NUM-1:0]                overflow_o,
    output logic [CH_NUM-1:0]                underflow_o
);

    localparam int W = CNT_BITWIDTH;

    localparam logic [W-1:0] MAX_C   = W'(MAX_VALUE);
    localparam logic [W-1:0] RST_C   = W'(RESET_VALUE);
    localparam logic [W-1:0] AE_C    = W'(ALMOST_EMPTY_LEVEL);
    localparam logic [W-1:0] AF_C    = W'(ALMOST_FULL_LEVEL);
    localparam logic [W-1:0] ONE_C   = W'(1);
    localparam logic [W-1:0] ZERO_C  = '0;
    localparam bit           WRAP_EN = (WRAP_MODE != 0);

    logic [W-1:0]      cnt_q [CH_NUM];
    logic [W-1:0]      cnt_d [CH_NUM];
    logic [CH_NUM-1:0] ovf_q;
    logic [CH_NUM-1:0] unf_q;
    logic [CH_NUM-1:0] ovf_set;
    logic [CH_NUM-1:0] unf_set;

    // Per-channel next count and error events: load beats inc/dec, inc+dec together is a no-op.
    // The upper bound is MAX_VALUE, never the natural 2**W rollover of the register.
    always_comb begin
        ovf_set = '0;
        unf_set = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            cnt_d[k] = cnt_q[k];
            if (load_i[k]) begin
                if (load_val_i[k*W +: W] > MAX_C) begin
                    cnt_d[k]   = MAX_C;
                    ovf_set[k] = 1'b1;
                end else begin
                    cnt_d[k] = load_val_i[k*W +: W];
                end
            end else if (inc_i[k] && !dec_i[k]) begin
                if (cnt_q[k] >= MAX_C) begin
                    ovf_set[k] = 1'b1;
                    cnt_d[k]   = WRAP_EN ? ZERO_C : MAX_C;
                end else begin
                    cnt_d[k] = cnt_q[k] + ONE_C;
                end
            end else if (dec_i[k] && !inc_i[k]) begin
                if (cnt_q[k] == ZERO_C) begin
                    unf_set[k] = 1'b1;
                    cnt_d[k]   = WRAP_EN ? MAX_C : ZERO_C;
                end else begin
                    cnt_d[k] = cnt_q[k] - ONE_C;
                end
            end
        end
    end

    // Count and sticky error registers; a new error event outranks a same-cycle clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < CH_NUM; k++) begin
                cnt_q[k] <= RST_C;
            end
            ovf_q <= '0;
            unf_q <= '0;
        end else begin
            for (int k = 0; k < CH_NUM; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            ovf_q <= (ovf_q & ~{CH_NUM{err_clr_i}}) | ovf_set;
            unf_q <= (unf_q & ~{CH_NUM{err_clr_i}}) | unf_set;
        end
    end

    // Outputs are decoded from registered state only, so no input reaches an output combinationally.
    for (genvar g = 0; g < CH_NUM; g++) begin : g_flags
        assign counter_o[g*W +: W] = cnt_q[g];
        assign full_o[g]           = (cnt_q[g] == MAX_C);
        assign empty_o[g]          = (cnt_q[g] == ZERO_C);
        assign almost_full_o[g]    = (cnt_q[g] >= AF_C);
        assign almost_empty_o[g]   = (cnt_q[g] <= AE_C);
    end

    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

endmodule

// File: tb/tb_credit_counter_nch.sv
// tb/tb_credit_counter_nch.sv - table-driven scoreboard bench for credit_counter_nch
module tb_credit_counter_nch;

    typedef struct {
        int          dut;
        logic        rst;
        logic        clr;
        logic [3:0]  inc;
        logic [3:0]  dec;
        logic [3:0]  load;
        logic [31:0] lval;
        logic [31:0] cnt;
        logic [3:0]  full;
        logic [3:0]  empty;
        logic [3:0]  af;
        logic [3:0]  ae;
        logic [3:0]  ovf;
        logic [3:0]  unf;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    vec_t tbl [$];
    vec_t exp_q [$];

    // default instance: 4 ch x 8 bit, max 255, saturating
    logic        d_rst = 0, d_clr = 0;
    logic [3:0]  d_inc = 0, d_dec = 0, d_load = 0;
    logic [31:0] d_lval = 0;
    logic [31:0] d_cnt;
    logic [3:0]  d_full, d_empty, d_af, d_ae, d_ovf, d_unf;

    // wrap instance: 2 ch x 8 bit, max 9, wrapping
    logic        w_rst = 0, w_clr = 0;
    logic [1:0]  w_inc = 0, w_dec = 0, w_load = 0;
    logic [15:0] w_lval = 0;
    logic [15:0] w_cnt;
    logic [1:0]  w_full, w_empty, w_af, w_ae, w_ovf, w_unf;

    // 9-bit instance: 2 ch, max 200, saturating
    logic        s_rst = 0, s_clr = 0;
    logic [1:0]  s_inc = 0, s_dec = 0, s_load = 0;
    logic [17:0] s_lval = 0;
    logic [17:0] s_cnt;
    logic [1:0]  s_full, s_empty, s_af, s_ae, s_ovf, s_unf;

    credit_counter_nch u_def (
        .clk_i(clk), .rst_i(d_rst), .inc_i(d_inc), .dec_i(d_dec), .load_i(d_load),
        .load_val_i(d_lval), .err_clr_i(d_clr), .counter_o(d_cnt), .full_o(d_full),
        .empty_o(d_empty), .almost_full_o(d_af), .almost_empty_o(d_ae),
        .overflow_o(d_ovf), .underflow_o(d_unf)
    );

    credit_counter_nch #(
        .CNT_BITWIDTH(8), .CH_NUM(2), .MAX_VALUE(9), .RESET_VALUE(0),
        .ALMOST_EMPTY_LEVEL(2), .ALMOST_FULL_LEVEL(8), .WRAP_MODE(1)
    ) u_wrap (
        .clk_i(clk), .rst_i(w_rst), .inc_i(w_inc), .dec_i(w_dec), .load_i(w_load),
        .load_val_i(w_lval), .err_clr_i(w_clr), .counter_o(w_cnt), .full_o(w_full),
        .empty_o(w_empty), .almost_full_o(w_af), .almost_empty_o(w_ae),
        .overflow_o(w_ovf), .underflow_o(w_unf)
    );

    credit_counter_nch #(
        .CNT_BITWIDTH(9), .CH_NUM(2), .MAX_VALUE(200), .RESET_VALUE(0),
        .ALMOST_EMPTY_LEVEL(10), .ALMOST_FULL_LEVEL(190), .WRAP_MODE(0)
    ) u_sat (
        .clk_i(clk), .rst_i(s_rst), .inc_i(s_inc), .dec_i(s_dec), .load_i(s_load),
        .load_val_i(s_lval), .err_clr_i(s_clr), .counter_o(s_cnt), .full_o(s_full),
        .empty_o(s_empty), .almost_full_o(s_af), .almost_empty_o(s_ae),
        .overflow_o(s_ovf), .underflow_o(s_unf)
    );

    function automatic vec_t mk(int dut, logic rst, logic clr, logic [3:0] inc, logic [3:0] dec,
                                logic [3:0] load, logic [31:0] lval, logic [31:0] cnt,
                                logic [3:0] full, logic [3:0] empty, logic [3:0] af,
                                logic [3:0] ae, logic [3:0] ovf, logic [3:0] unf, string name);
        vec_t v;
        v.dut = dut; v.rst = rst; v.clr = clr; v.inc = inc; v.dec = dec; v.load = load;
        v.lval = lval; v.cnt = cnt; v.full = full; v.empty = empty; v.af = af; v.ae = ae;
        v.ovf = ovf; v.unf = unf; v.name = name;
        return v;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
    task automatic step(input vec_t v);
        vec_t        e;
        logic [55:0] act;
        logic [55:0] want;
        d_rst = 0; d_clr = 0; d_inc = 0; d_dec = 0; d_load = 0; d_lval = 0;
        w_rst = 0; w_clr = 0; w_inc = 0; w_dec = 0; w_load = 0; w_lval = 0;
        s_rst = 0; s_clr = 0; s_inc = 0; s_dec = 0; s_load = 0; s_lval = 0;
        case (v.dut)
            0: begin
                d_rst = v.rst; d_clr = v.clr; d_inc = v.inc; d_dec = v.dec;
                d_load = v.load; d_lval = v.lval;
            end
            1: begin
                w_rst = v.rst; w_clr = v.clr; w_inc = v.inc[1:0]; w_dec = v.dec[1:0];
                w_load = v.load[1:0]; w_lval = v.lval[15:0];
            end
            default: begin
                s_rst = v.rst; s_clr = v.clr; s_inc = v.inc[1:0]; s_dec = v.dec[1:0];
                s_load = v.load[1:0]; s_lval = v.lval[17:0];
            end
        endcase
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        case (e.dut)
            0: act = {d_cnt, d_full, d_empty, d_af, d_ae, d_ovf, d_unf};
            1: act = {16'b0, w_cnt, 2'b0, w_full, 2'b0, w_empty, 2'b0, w_af, 2'b0, w_ae,
                      2'b0, w_ovf, 2'b0, w_unf};
            default: act = {14'b0, s_cnt, 2'b0, s_full, 2'b0, s_empty, 2'b0, s_af, 2'b0, s_ae,
                            2'b0, s_ovf, 2'b0, s_unf};
        endcase
        want = {e.cnt, e.full, e.empty, e.af, e.ae, e.ovf, e.unf};
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got cnt/full/empty/af/ae/ovf/unf=%h want %h", e.name, act, want);
        end
    endtask

    initial begin
        // default instance: sticky flags, inc+dec at bounds, clear/set race, reset over load
        tbl.push_back(mk(0,1,0,4'h0,4'h0,4'h0,32'h0,       32'h00000000,4'h0,4'hF,4'h0,4'hF,4'h0,4'h0,"d_reset"));
        tbl.push_back(mk(0,0,0,4'h1,4'h0,4'h0,32'h0,       32'h00000001,4'h0,4'hE,4'h0,4'hF,4'h0,4'h0,"d_inc_ch0"));
        tbl.push_back(mk(0,0,0,4'h0,4'h2,4'h0,32'h0,       32'h00000001,4'h0,4'hE,4'h0,4'hF,4'h0,4'h2,"d_unf_ch1_sat"));
        tbl.push_back(mk(0,0,0,4'h0,4'h0,4'h4,32'h00FA0000,32'h00FA0001,4'h0,4'hA,4'h4,4'hB,4'h0,4'h2,"d_load_ch2_250"));
        tbl.push_back(mk(0,0,0,4'h4,4'h4,4'h0,32'h0,       32'h00FA0001,4'h0,4'hA,4'h4,4'hB,4'h0,4'h2,"d_incdec_mid"));
        tbl.push_back(mk(0,0,0,4'h0,4'h0,4'h8,32'hFF000000,32'hFFFA0001,4'h8,4'h2,4'hC,4'h3,4'h0,4'h2,"d_load_ch3_max"));
        tbl.push_back(mk(0,0,0,4'h8,4'h0,4'h0,32'h0,       32'hFFFA0001,4'h8,4'h2,4'hC,4'h3,4'h8,4'h2,"d_ovf_ch3_sat"));
        tbl.push_back(mk(0,0,1,4'h0,4'h0,4'h0,32'h0,       32'hFFFA0001,4'h8,4'h2,4'hC,4'h3,4'h0,4'h0,"d_clr_all"));
        tbl.push_back(mk(0,0,0,4'hA,4'hA,4'h0,32'h0,       32'hFFFA0001,4'h8,4'h2,4'hC,4'h3,4'h0,4'h0,"d_incdec_bounds"));
        tbl.push_back(mk(0,0,0,4'h0,4'h1,4'h0,32'h0,       32'hFFFA0000,4'h8,4'h3,4'hC,4'h3,4'h0,4'h0,"d_dec_ch0"));
        tbl.push_back(mk(0,0,1,4'h8,4'h0,4'h0,32'h0,       32'hFFFA0000,4'h8,4'h3,4'hC,4'h3,4'h8,4'h0,"d_clr_vs_set"));
        tbl.push_back(mk(0,0,0,4'h0,4'h1,4'h0,32'h0,       32'hFFFA0000,4'h8,4'h3,4'hC,4'h3,4'h8,4'h1,"d_unf_ch0"));
        tbl.push_back(mk(0,0,1,4'h0,4'h0,4'h0,32'h0,       32'hFFFA0000,4'h8,4'h3,4'hC,4'h3,4'h0,4'h0,"d_clr_alone"));
        tbl.push_back(mk(0,0,0,4'h8,4'h0,4'h0,32'h0,       32'hFFFA0000,4'h8,4'h3,4'hC,4'h3,4'h8,4'h0,"d_ovf_again"));
        tbl.push_back(mk(0,1,0,4'hF,4'h0,4'hF,32'h05050505,32'h00000000,4'h0,4'hF,4'h0,4'hF,4'h0,4'h0,"d_rst_over_load"));
        tbl.push_back(mk(0,0,0,4'hF,4'h0,4'h0,32'h0,       32'h01010101,4'h0,4'h0,4'h0,4'hF,4'h0,4'h0,"d_inc_all"));
        tbl.push_back(mk(0,0,0,4'h0,4'h0,4'h1,32'h0000000B,32'h0101010B,4'h0,4'h0,4'h0,4'hE,4'h0,4'h0,"d_ae_edge_11"));
        tbl.push_back(mk(0,0,0,4'h0,4'h1,4'h0,32'h0,       32'h0101010A,4'h0,4'h0,4'h0,4'hF,4'h0,4'h0,"d_ae_edge_10"));
        // wrap instance: max 9
        tbl.push_back(mk(1,1,0,4'h0,4'h0,4'h0,32'h0,   32'h0000,4'h0,4'h3,4'h0,4'h3,4'h0,4'h0,"w_reset"));
        tbl.push_back(mk(1,0,0,4'h0,4'h1,4'h0,32'h0,   32'h0009,4'h1,4'h2,4'h1,4'h2,4'h0,4'h1,"w_dec_wrap"));
        tbl.push_back(mk(1,0,0,4'h1,4'h0,4'h0,32'h0,   32'h0000,4'h0,4'h3,4'h0,4'h3,4'h1,4'h1,"w_inc_wrap"));
        tbl.push_back(mk(1,0,1,4'h3,4'h3,4'h0,32'h0,   32'h0000,4'h0,4'h3,4'h0,4'h3,4'h0,4'h0,"w_incdec_zero"));
        tbl.push_back(mk(1,0,0,4'h0,4'h0,4'h1,32'h0009,32'h0009,4'h1,4'h2,4'h1,4'h2,4'h0,4'h0,"w_load_max"));
        tbl.push_back(mk(1,0,0,4'h1,4'h1,4'h0,32'h0,   32'h0009,4'h1,4'h2,4'h1,4'h2,4'h0,4'h0,"w_incdec_max"));
        tbl.push_back(mk(1,0,0,4'h0,4'h0,4'h2,32'h0C00,32'h0909,4'h3,4'h0,4'h3,4'h0,4'h2,4'h0,"w_load_clip"));
        // 9-bit instance: max 200
        tbl.push_back(mk(2,1,0,4'h0,4'h0,4'h0,32'h0,      32'h00000,4'h0,4'h3,4'h0,4'h3,4'h0,4'h0,"s_reset"));
        tbl.push_back(mk(2,0,0,4'h1,4'h0,4'h1,32'd300,    32'h000C8,4'h1,4'h2,4'h1,4'h2,4'h1,4'h0,"s_load300_inc"));
        tbl.push_back(mk(2,0,0,4'h0,4'h0,4'h2,32'h19000,  32'h190C8,4'h3,4'h0,4'h3,4'h0,4'h1,4'h0,"s_load200_exact"));
        tbl.push_back(mk(2,0,0,4'h2,4'h0,4'h0,32'h0,      32'h190C8,4'h3,4'h0,4'h3,4'h0,4'h3,4'h0,"s_inc_sat200"));
        tbl.push_back(mk(2,0,0,4'h0,4'h1,4'h0,32'h0,      32'h190C7,4'h2,4'h0,4'h3,4'h0,4'h3,4'h0,"s_dec_199"));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // ch0 inc held for 255 cycles from reset, then one extra inc saturates with overflow
        step(mk(0,1,0,4'h0,4'h0,4'h0,32'h0,32'h0,4'h0,4'hF,4'h0,4'hF,4'h0,4'h0,"hold_reset"));
        for (int i = 1; i <= 255; i++) begin
            step(mk(0,0,0,4'h1,4'h0,4'h0,32'h0, 32'(i),
                    {3'b000, i == 255}, 4'hE, {3'b000, i >= 250}, {3'b111, i <= 10},
                    4'h0, 4'h0, $sformatf("hold_inc_%0d", i)));
        end
        step(mk(0,0,0,4'h1,4'h0,4'h0,32'h0,32'h000000FF,4'h1,4'hE,4'h1,4'hE,4'h1,4'h0,"hold_inc_ovf"));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/credit_counter_nch.md
CREDIT_COUNTER_NCH -- requirements
Module: credit_counter_nch

Interface
REQ-001 The block SHALL have parameter CNT_BITWIDTH, default 8, giving the width of each channel counter.
REQ-002 The block SHALL have parameter CH_NUM, default 4, giving the number of independent counter channels (1..32).
REQ-003 The block SHALL have parameter MAX_VALUE, default 2**CNT_BITWIDTH-1, giving the upper count bound, legal range 1..2**CNT_BITWIDTH-1.
REQ-004 The block SHALL have parameter RESET_VALUE, default 0, giving the count loaded on reset, legal range 0..MAX_VALUE.
REQ-005 The block SHALL have parameter ALMOST_EMPTY_LEVEL, default 10, giving the almost-empty threshold, which SHALL be at most ALMOST_FULL_LEVEL.
REQ-006 The block SHALL have parameter ALMOST_FULL_LEVEL, default 250, giving the almost-full threshold, which SHALL be at most MAX_VALUE.
REQ-007 The block SHALL have parameter WRAP_MODE, default 0, where 0 = saturate at the bounds and 1 = wrap at the bounds.
REQ-008 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-009 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-010 The block SHALL have port inc_i, input, CH_NUM bits: per-channel increment request.
REQ-011 The block SHALL have port dec_i, input, CH_NUM bits: per-channel decrement request.
REQ-012 The block SHALL have port load_i, input, CH_NUM bits: per-channel load strobe.
REQ-013 The block SHALL have port load_val_i, input, CH_NUM*CNT_BITWIDTH bits: per-channel load value, channel k at bits [k*CNT_BITWIDTH +: CNT_BITWIDTH].
REQ-014 The block SHALL have port err_clr_i, input, 1 bit: clears all sticky error flags.
REQ-015 The block SHALL have port counter_o, output, CH_NUM*CNT_BITWIDTH bits: registered count of each channel, packed as load_val_i.
REQ-016 The block SHALL have ports full_o, empty_o, almost_full_o and almost_empty_o, each output, CH_NUM bits: per-channel level flags.
REQ-017 The block SHALL have ports overflow_o and underflow_o, each output, CH_NUM bits: per-channel sticky error flags.

Function
REQ-018 Each channel SHALL update independently, with one clock of latency from request to counter_o.
REQ-019 Per-channel priority SHALL be rst_i, then load_i, then inc_i/dec_i.
REQ-020 When load_i=1, the count SHALL become min(load_val, MAX_VALUE); if load_val > MAX_VALUE, overflow SHALL also be set; inc_i and dec_i SHALL be ignored that cycle.
REQ-021 When inc_i=1 and dec_i=1 in the same cycle, the count SHALL be unchanged and no error flag SHALL be set, including at either bound.
REQ-022 When only inc_i=1 and count<MAX_VALUE, the count SHALL become count+1.
REQ-023 When only dec_i=1 and count>0, the count SHALL become count-1.
REQ-024 When only inc_i=1 and count==MAX_VALUE, overflow SHALL be set; the count SHALL hold in WRAP_MODE=0 and become 0 in WRAP_MODE=1.
REQ-025 When only dec_i=1 and count==0, underflow SHALL be set; the count SHALL hold in WRAP_MODE=0 and become MAX_VALUE in WRAP_MODE=1.
REQ-026 Arithmetic SHALL never wrap at 2**CNT_BITWIDTH when MAX_VALUE < 2**CNT_BITWIDTH-1; the bound is MAX_VALUE only.
REQ-027 Level flags SHALL be combinational from the registered count, aligned with counter_o:
- full_o: count==MAX_VALUE
- empty_o: count==0
- almost_full_o: count>=ALMOST_FULL_LEVEL
- almost_empty_o: count<=ALMOST_EMPTY_LEVEL
REQ-028 Once set, overflow_o and underflow_o SHALL stay at 1 until err_clr_i=1 or rst_i=1.
REQ-029 When err_clr_i=1 coincides with a new error event on a channel, that flag SHALL be 1 in the next cycle (set wins).
REQ-030 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-031 On rst_i=1 at a clock edge, every channel count SHALL become RESET_VALUE and all overflow_o and underflow_o bits SHALL become 0, regardless of other inputs.
REQ-032 After reset, the level flags SHALL reflect RESET_VALUE; with defaults, empty_o and almost_empty_o SHALL be all ones and full_o and almost_full_o all zeros.
REQ-033 A reset asserted mid-operation SHALL take effect at the next clock edge, override any load or inc/dec in that cycle, and leave no residual state.

Verification
REQ-034 Bench SHALL cover: defaults, ch0 inc held for 255 cycles, then 1 more inc -> count 255, full_o[0]=1, overflow_o[0]=1, other channels unchanged at 0.
REQ-035 Bench SHALL cover: WRAP_MODE=1, MAX_VALUE=9, dec at count 0 -> count 9, underflow=1; then inc -> count 0.
REQ-036 Bench SHALL cover: inc and dec together at count 0 and at MAX_VALUE -> count unchanged, no error flag.
REQ-037 Bench SHALL cover: load_val 300 with MAX_VALUE=200, CNT_BITWIDTH=9, plus inc in the same cycle -> count 200, overflow=1.
REQ-038 Bench SHALL cover: err_clr_i plus a new overflow in the same cycle -> flag stays 1; err_clr_i alone -> flag 0 next cycle.
REQ-039 Bench SHALL cover: rst_i asserted during a load on all channels -> all counts RESET_VALUE and all errors 0 next cycle.
